// File: rtl/uart_rx.sv
// Fixed-baud UART receiver: 2-flop synchronised line, centre-of-slot sampling from a
// half-bit-slot counter, one-cycle ready / frame-error strobes.
module uart_rx #(
    parameter int p_BITSLOT_HALF_PERIOD = 8,
    parameter int p_DATA_BITS           = 8,
    parameter int p_STOP_BITS           = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_rx,
    output logic [p_DATA_BITS-1:0] o_data,
    output logic                   o_data_ready,
    output logic                   o_frame_err
);

    localparam int H     = p_BITSLOT_HALF_PERIOD;
    localparam int D     = p_DATA_BITS;
    localparam int S     = p_STOP_BITS;
    localparam int CNT_W = $clog2(2 * H) + 1;
    localparam int MAXB  = (D > S) ? D : S;
    localparam int IDX_W = $clog2(MAXB) + 1;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(2 * H - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(D - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(S - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             ready_d, ferr_d;
    logic             sample_data;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic [D-1:0]     shift_q, shifted;

    // Synchroniser presets to the idle level so reset release never looks like a start edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_rx};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            o_data_ready <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            o_data_ready <= ready_d;
            o_frame_err  <= ferr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        err_d       = err_q;
        ready_d     = 1'b0;
        ferr_d      = 1'b0;
        sample_data = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    idx_d   = '0;
                    cnt_d   = SLOT_LOAD;
                    err_d   = 1'b0;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    sample_data = 1'b1;
                    cnt_d       = SLOT_LOAD;
                    if (idx_q == LAST_DATA) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (idx_q == LAST_STOP) begin
                    // Last stop sample: the verdict includes this sample directly
                    state_d = WAIT_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    if (err_q || !rx_s) begin
                        ferr_d = 1'b1;
                    end else begin
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = SLOT_LOAD;
                    idx_d = idx_q + IDX_ONE;
                    if (!rx_s) begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // LSB arrives first, so shift right and insert at the top
    always_comb begin
        shifted        = shift_q >> 1;
        shifted[D-1]   = rx_s;
    end

    always_ff @(posedge i_clk) begin
        if (sample_data) begin
            shift_q <= shifted;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data <= '0;
        end else if (ready_d) begin
            o_data <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: four instances with different frame shapes, per-scenario tasks,
// and a frame-level model giving expected words, strobe kinds and strobe cycles.
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       rx [4];
    logic [0:0] da;
    logic [7:0] db, dc, dd;
    logic       rdy [4];
    logic       ferr [4];
    logic [31:0] dat [4];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rdy_cnt [4] = '{0, 0, 0, 0};
    int err_cnt [4] = '{0, 0, 0, 0};
    int last_rdy_cyc [4] = '{0, 0, 0, 0};
    int last_err_cyc [4] = '{0, 0, 0, 0};
    int both_cnt = 0;
    logic [31:0] words [4][64];

    uart_rx #(.p_BITSLOT_HALF_PERIOD(1), .p_DATA_BITS(1), .p_STOP_BITS(3)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[0]),
        .o_data(da), .o_data_ready(rdy[0]), .o_frame_err(ferr[0]));
    uart_rx #(.p_BITSLOT_HALF_PERIOD(8), .p_DATA_BITS(8), .p_STOP_BITS(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[1]),
        .o_data(db), .o_data_ready(rdy[1]), .o_frame_err(ferr[1]));
    uart_rx #(.p_BITSLOT_HALF_PERIOD(8), .p_DATA_BITS(8), .p_STOP_BITS(2)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[2]),
        .o_data(dc), .o_data_ready(rdy[2]), .o_frame_err(ferr[2]));
    uart_rx #(.p_BITSLOT_HALF_PERIOD(4), .p_DATA_BITS(8), .p_STOP_BITS(1)) dut_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[3]),
        .o_data(dd), .o_data_ready(rdy[3]), .o_frame_err(ferr[3]));

    assign dat[0] = {31'b0, da};
    assign dat[1] = {24'b0, db};
    assign dat[2] = {24'b0, dc};
    assign dat[3] = {24'b0, dd};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rdy[i]) begin
                words[i][rdy_cnt[i] % 64] = dat[i];
                rdy_cnt[i]                = rdy_cnt[i] + 1;
                last_rdy_cyc[i]           = cyc;
            end
            if (ferr[i]) begin
                err_cnt[i]      = err_cnt[i] + 1;
                last_err_cyc[i] = cyc;
            end
            if (rdy[i] && ferr[i]) both_cnt = both_cnt + 1;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a whole frame; stop bit j comes from stops[j]. Line is left at the last stop level.
    task automatic send_frame(input int inst, input int h, input int d, input int s,
                              input logic [31:0] data, input logic [31:0] stops, output int fall);
        rx[inst] = 1'b0;
        fall = cyc;
        wait_cycles(2 * h);
        for (int k = 0; k < d; k++) begin
            rx[inst] = data[k];
            wait_cycles(2 * h);
        end
        for (int j = 0; j < s; j++) begin
            rx[inst] = stops[j];
            wait_cycles(2 * h);
        end
    endtask

    // Strobe cycle: line edge + 2 sync clocks = T0, then H + 2H*(D+S) + 1
    function automatic int strobe_cycle(input int fall, input int h, input int d, input int s);
        return fall + 2 + h + 2 * h * (d + s) + 1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) rx[i] = 1'b1;
        wait_cycles(3);
        tests_run++;
        if ({da, db, dc, dd} !== 25'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h/%h/%h/%h want 0", da, db, dc, dd);
        end
        tests_run++;
        if ({rdy[0], rdy[1], rdy[2], rdy[3], ferr[0], ferr[1], ferr[2], ferr[3]} !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_strobes: some strobe high during reset, want all 0");
        end
        rst_n = 1'b1;
        wait_cycles(10);
        tests_run++;
        if (rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3] + err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3] !== 0) begin
            tests_failed++;
            $display("FAIL reset_idle: strobes after release on idle line, want none");
        end
    endtask

    task automatic test_short_frame();
        int r0, e0, fall;
        r0 = rdy_cnt[0];
        e0 = err_cnt[0];
        send_frame(0, 1, 1, 3, 32'h1, 32'h7, fall);
        rx[0] = 1'b1;
        wait_cycles(10);
        tests_run++;
        if (rdy_cnt[0] - r0 !== 1 || err_cnt[0] - e0 !== 0) begin
            tests_failed++;
            $display("FAIL short_strobes: ready=%0d err=%0d want 1/0", rdy_cnt[0] - r0, err_cnt[0] - e0);
        end
        tests_run++;
        if (da !== 1'b1) begin
            tests_failed++;
            $display("FAIL short_data: got %b want 1", da);
        end
        tests_run++;
        if (last_rdy_cyc[0] !== strobe_cycle(fall, 1, 1, 3)) begin
            tests_failed++;
            $display("FAIL short_timing: got %0d want %0d", last_rdy_cyc[0], strobe_cycle(fall, 1, 1, 3));
        end
    endtask

    task automatic test_timing();
        int r0, e0, fall;
        r0 = rdy_cnt[1];
        e0 = err_cnt[1];
        send_frame(1, 8, 8, 1, 32'hA5, 32'h1, fall);
        rx[1] = 1'b1;
        wait_cycles(30);
        tests_run++;
        if (rdy_cnt[1] - r0 !== 1 || err_cnt[1] - e0 !== 0) begin
            tests_failed++;
            $display("FAIL a5_strobes: ready=%0d err=%0d want 1/0", rdy_cnt[1] - r0, err_cnt[1] - e0);
        end
        tests_run++;
        if (db !== 8'hA5) begin
            tests_failed++;
            $display("FAIL a5_data: got %h want a5", db);
        end
        tests_run++;
        if (last_rdy_cyc[1] !== fall + 2 + 8 + 16 * 9 + 1) begin
            tests_failed++;
            $display("FAIL a5_latency: got %0d want %0d", last_rdy_cyc[1], fall + 2 + 8 + 16 * 9 + 1);
        end
    endtask

    task automatic test_glitch();
        int r0, e0, fall;
        r0 = rdy_cnt[1];
        e0 = err_cnt[1];
        rx[1] = 1'b0;
        wait_cycles(5);
        rx[1] = 1'b1;
        wait_cycles(40);
        tests_run++;
        if (rdy_cnt[1] - r0 !== 0 || err_cnt[1] - e0 !== 0) begin
            tests_failed++;
            $display("FAIL glitch_strobes: ready=%0d err=%0d want 0/0", rdy_cnt[1] - r0, err_cnt[1] - e0);
        end
        tests_run++;
        if (db !== 8'hA5) begin
            tests_failed++;
            $display("FAIL glitch_data: got %h want a5", db);
        end
        send_frame(1, 8, 8, 1, 32'h3E, 32'h1, fall);
        rx[1] = 1'b1;
        wait_cycles(30);
        tests_run++;
        if (db !== 8'h3E || rdy_cnt[1] - r0 !== 1 || last_rdy_cyc[1] !== strobe_cycle(fall, 8, 8, 1)) begin
            tests_failed++;
            $display("FAIL glitch_recover: data=%h ready=%0d want 3e/1", db, rdy_cnt[1] - r0);
        end
    endtask

    task automatic test_frame_error();
        int r0, e0, fall;
        r0 = rdy_cnt[2];
        e0 = err_cnt[2];
        send_frame(2, 8, 8, 2, 32'h96, 32'h3, fall);
        rx[2] = 1'b1;
        wait_cycles(30);
        tests_run++;
        if (dc !== 8'h96 || rdy_cnt[2] - r0 !== 1) begin
            tests_failed++;
            $display("FAIL ferr_setup: data=%h ready=%0d want 96/1", dc, rdy_cnt[2] - r0);
        end
        send_frame(2, 8, 8, 2, 32'h3C, 32'h1, fall);
        wait_cycles(100);
        tests_run++;
        if (err_cnt[2] - e0 !== 1 || rdy_cnt[2] - r0 !== 1) begin
            tests_failed++;
            $display("FAIL ferr_strobes: err=%0d ready=%0d want 1/1", err_cnt[2] - e0, rdy_cnt[2] - r0);
        end
        tests_run++;
        if (last_err_cyc[2] !== strobe_cycle(fall, 8, 8, 2)) begin
            tests_failed++;
            $display("FAIL ferr_timing: got %0d want %0d", last_err_cyc[2], strobe_cycle(fall, 8, 8, 2));
        end
        tests_run++;
        if (dc !== 8'h96) begin
            tests_failed++;
            $display("FAIL ferr_data_kept: got %h want 96", dc);
        end
        rx[2] = 1'b1;
        wait_cycles(20);
        tests_run++;
        if (err_cnt[2] - e0 !== 1 || rdy_cnt[2] - r0 !== 1) begin
            tests_failed++;
            $display("FAIL break_single: err=%0d ready=%0d want 1/1", err_cnt[2] - e0, rdy_cnt[2] - r0);
        end
    endtask

    task automatic test_back_to_back();
        int r0, fall;
        int falls [3];
        logic [7:0] sent [3];
        sent[0] = 8'h00;
        sent[1] = 8'hFF;
        sent[2] = 8'h55;
        r0 = rdy_cnt[3];
        for (int f = 0; f < 3; f++) begin
            send_frame(3, 4, 8, 1, {24'b0, sent[f]}, 32'h1, fall);
            falls[f] = fall;
        end
        rx[3] = 1'b1;
        wait_cycles(20);
        tests_run++;
        if (rdy_cnt[3] - r0 !== 3) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d want 3", rdy_cnt[3] - r0);
        end
        for (int f = 0; f < 3; f++) begin
            tests_run++;
            if (words[3][(r0 + f) % 64] !== {24'b0, sent[f]}) begin
                tests_failed++;
                $display("FAIL b2b_word%0d: got %h want %h", f, words[3][(r0 + f) % 64], sent[f]);
            end
        end
        tests_run++;
        if (last_rdy_cyc[3] !== strobe_cycle(falls[2], 4, 8, 1)) begin
            tests_failed++;
            $display("FAIL b2b_timing: got %0d want %0d", last_rdy_cyc[3], strobe_cycle(falls[2], 4, 8, 1));
        end
    endtask

    // Frame-level model: good iff every stop bit is 1; o_data tracks the last good word only
    task automatic test_random();
        int r0, e0, fall, exp_r, exp_e;
        logic [7:0]  model_word;
        logic [31:0] data, stops;
        r0 = rdy_cnt[2];
        e0 = err_cnt[2];
        exp_r = 0;
        exp_e = 0;
        model_word = 8'hC3;
        send_frame(2, 8, 8, 2, 32'hC3, 32'h3, fall);
        exp_r++;
        rx[2] = 1'b1;
        wait_cycles(30);
        for (int n = 0; n < 20; n++) begin
            data  = $urandom & 32'hFF;
            stops = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 32'h3;
            send_frame(2, 8, 8, 2, data, stops, fall);
            rx[2] = 1'b1;
            wait_cycles(30);
            if (stops[1:0] == 2'b11) begin
                model_word = data[7:0];
                exp_r++;
            end else begin
                exp_e++;
            end
            tests_run++;
            if (rdy_cnt[2] - r0 !== exp_r || err_cnt[2] - e0 !== exp_e) begin
                tests_failed++;
                $display("FAIL rand%0d_strobes: ready=%0d err=%0d want %0d/%0d", n,
                         rdy_cnt[2] - r0, err_cnt[2] - e0, exp_r, exp_e);
            end
            tests_run++;
            if (dc !== model_word) begin
                tests_failed++;
                $display("FAIL rand%0d_data: got %h want %h", n, dc, model_word);
            end
            tests_run++;
            if (((stops[1:0] == 2'b11) ? last_rdy_cyc[2] : last_err_cyc[2]) !== strobe_cycle(fall, 8, 8, 2)) begin
                tests_failed++;
                $display("FAIL rand%0d_timing: want strobe at %0d", n, strobe_cycle(fall, 8, 8, 2));
            end
        end
    endtask

    task automatic test_reset_abort();
        int r0, e0, fall;
        r0 = rdy_cnt[1];
        e0 = err_cnt[1];
        rx[1] = 1'b0;
        wait_cycles(16);
        rx[1] = 1'b1;
        wait_cycles(40);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (db !== 8'h00 || rdy[1] !== 1'b0 || ferr[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_in_reset: data=%h ready=%b err=%b want 00/0/0", db, rdy[1], ferr[1]);
        end
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(200);
        tests_run++;
        if (rdy_cnt[1] - r0 !== 0 || err_cnt[1] - e0 !== 0 || db !== 8'h00) begin
            tests_failed++;
            $display("FAIL abort_no_strobe: ready=%0d err=%0d data=%h want 0/0/00",
                     rdy_cnt[1] - r0, err_cnt[1] - e0, db);
        end
        send_frame(1, 8, 8, 1, 32'h81, 32'h1, fall);
        rx[1] = 1'b1;
        wait_cycles(30);
        tests_run++;
        if (db !== 8'h81 || rdy_cnt[1] - r0 !== 1 || last_rdy_cyc[1] !== strobe_cycle(fall, 8, 8, 1)) begin
            tests_failed++;
            $display("FAIL abort_next: data=%h ready=%0d want 81/1", db, rdy_cnt[1] - r0);
        end
    endtask

    task automatic test_exclusive();
        tests_run++;
        if (both_cnt !== 0) begin
            tests_failed++;
            $display("FAIL strobe_overlap: got %0d cycles with both strobes, want 0", both_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) rx[i] = 1'b1;
        test_reset();
        test_short_frame();
        test_timing();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
